// File: rtl/seq_detect_ctrl.sv
// Run controller for the serial pattern detector: programmable pattern,
// arm/disarm, match counting against a target, timeout, status reporting.
module seq_detect_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int TO_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [3:0]       cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic [TO_W-1:0]  cfg_timeout,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic             in,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             done,
  output logic             timed_out,
  output logic             busy,
  output logic [1:0]       state
);
  localparam int LEN_W = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;

  typedef struct packed {
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic             overlap;
    logic [CNT_W-1:0] target;
    logic [TO_W-1:0]  timeout;
  } cfg_t;

  localparam cfg_t CFG_RST = '{pattern: PAT_W'(2), len: LEN_W'(4), overlap: 1'b1,
                               target: '0, timeout: '0};

  state_t           st, st_nx;
  cfg_t             cfg_q, run_q, cfg_in;
  logic [PAT_W-2:0] hist;
  logic [LEN_W-1:0] bits_seen;
  logic [TO_W-1:0]  timer;
  logic [PAT_W-1:0] win, mask;
  logic             cfg_fire, run_entry, hit, tgt_hit, to_hit;
  logic             match_d, done_d, to_d;
  logic [CNT_W-1:0] cnt_d;

  assign cfg_ready = (st != RUN);
  assign busy      = (st == RUN);
  assign state     = st;
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign run_entry = (st != RUN) && start;

  // Length 0 or beyond the pattern register means "use the full width".
  always_comb begin
    cfg_in.pattern = cfg_pattern;
    cfg_in.len     = (cfg_len == 4'd0 || int'(cfg_len) > PAT_W) ? LEN_W'(PAT_W) : LEN_W'(cfg_len);
    cfg_in.overlap = cfg_overlap;
    cfg_in.target  = cfg_target;
    cfg_in.timeout = cfg_timeout;
  end

  // Newest bit sits at bit 0; the oldest bit of the window lines up with pattern[len-1].
  assign win     = {hist, in};
  assign mask    = ~({PAT_W{1'b1}} << run_q.len);
  assign hit     = (st == RUN) && in_valid && (bits_seen >= run_q.len - LEN_W'(1)) &&
                   (((win ^ run_q.pattern) & mask) == '0);
  assign tgt_hit = hit && (run_q.target != '0) && (match_count + CNT_W'(1) == run_q.target);
  assign to_hit  = (run_q.timeout != '0) && (timer == run_q.timeout - TO_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= IDLE;
    else       st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    case (st)
      IDLE, DONE: if (start) st_nx = RUN;
      RUN: begin
        if (abort)                  st_nx = IDLE;
        else if (tgt_hit || to_hit) st_nx = DONE;
      end
      default: st_nx = IDLE;
    endcase
  end

  // Abort wins over everything, so a completing bit in the abort cycle is dropped.
  always_comb begin
    match_d = 1'b0;
    cnt_d   = match_count;
    done_d  = done;
    to_d    = timed_out;
    case (st)
      IDLE, DONE: begin
        if (start) begin
          cnt_d  = '0;
          done_d = 1'b0;
          to_d   = 1'b0;
        end
      end
      RUN: begin
        if (!abort) begin
          if (hit) begin
            match_d = 1'b1;
            if (match_count != '1) cnt_d = match_count + CNT_W'(1);
          end
          if (tgt_hit) begin
            done_d = 1'b1;
          end else if (to_hit) begin
            done_d = 1'b1;
            to_d   = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // run_q snapshots the config at start so a same-edge cfg write only affects later runs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match       <= 1'b0;
      match_count <= '0;
      done        <= 1'b0;
      timed_out   <= 1'b0;
      cfg_q       <= CFG_RST;
      run_q       <= CFG_RST;
      hist        <= '0;
      bits_seen   <= '0;
      timer       <= '0;
    end else begin
      match       <= match_d;
      match_count <= cnt_d;
      done        <= done_d;
      timed_out   <= to_d;
      if (cfg_fire) cfg_q <= cfg_in;
      if (run_entry) begin
        run_q     <= cfg_q;
        hist      <= '0;
        bits_seen <= '0;
        timer     <= '0;
      end else if (st == RUN) begin
        timer <= timer + TO_W'(1);
        if (in_valid) begin
          if (hit && !run_q.overlap) begin
            hist      <= '0;
            bits_seen <= '0;
          end else begin
            hist <= win[PAT_W-2:0];
            if (bits_seen != LEN_W'(PAT_W)) bits_seen <= bits_seen + LEN_W'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: vector table, directed corner cases and a
// randomized run checked against a queue-based reference model.
module tb_seq_detect_ctrl;
  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
  localparam int TO_W  = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0, reset = 1'b1;
  logic             cfg_valid = 1'b0, cfg_ready;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [3:0]       cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic [CNT_W-1:0] cfg_target = '0;
  logic [TO_W-1:0]  cfg_timeout = '0;
  logic             start = 1'b0, abort = 1'b0, in_valid = 1'b0, in = 1'b0;
  logic             match, done, timed_out, busy;
  logic [CNT_W-1:0] match_count;
  logic [1:0]       state;

  seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_target(cfg_target), .cfg_timeout(cfg_timeout), .start(start), .abort(abort),
    .in_valid(in_valid), .in(in), .match(match), .match_count(match_count),
    .done(done), .timed_out(timed_out), .busy(busy), .state(state));

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: state 0=idle 1=run 2=done; history as a bit queue.
  int               m_st, m_cnt, m_timer;
  bit               m_done, m_to, m_match;
  bit               q[$];
  logic [PAT_W-1:0] c_pat, r_pat;
  int               c_len, c_tgt, c_tmo, r_len, r_tgt, r_tmo;
  bit               c_ov, r_ov;

  task automatic m_reset();
    m_st = 0; m_cnt = 0; m_timer = 0; m_done = 0; m_to = 0; m_match = 0;
    q.delete();
    c_pat = PAT_W'(2); c_len = 4; c_ov = 1; c_tgt = 0; c_tmo = 0;
    r_pat = c_pat; r_len = c_len; r_ov = c_ov; r_tgt = c_tgt; r_tmo = c_tmo;
  endtask

  task automatic m_step();
    bit acc, hit, tgt, tmo;
    int n;
    acc = cfg_valid && (m_st != 1);
    m_match = 0;
    if (m_st != 1) begin
      if (start) begin
        m_st = 1; m_cnt = 0; m_timer = 0; m_done = 0; m_to = 0; q.delete();
        r_pat = c_pat; r_len = c_len; r_ov = c_ov; r_tgt = c_tgt; r_tmo = c_tmo;
      end
    end else if (abort) begin
      m_st = 0;
    end else begin
      hit = 0;
      if (in_valid) begin
        q.push_back(in);
        n = q.size();
        if (n >= r_len) begin
          hit = 1;
          for (int j = 0; j < r_len; j++)
            if (q[n-1-j] != r_pat[j]) hit = 0;
        end
        if (q.size() > PAT_W) void'(q.pop_front());
        if (hit && !r_ov) q.delete();
      end
      tgt = hit && (r_tgt != 0) && (m_cnt + 1 == r_tgt);
      tmo = (r_tmo != 0) && (m_timer == r_tmo - 1);
      if (hit) begin
        m_match = 1;
        if (m_cnt < CMAX) m_cnt++;
      end
      if (tgt) begin
        m_st = 2; m_done = 1;
      end else if (tmo) begin
        m_st = 2; m_done = 1; m_to = 1;
      end
      m_timer++;
    end
    if (acc) begin
      c_pat = cfg_pattern;
      c_len = (cfg_len == 0 || cfg_len > PAT_W) ? PAT_W : int'(cfg_len);
      c_ov  = cfg_overlap; c_tgt = int'(cfg_target); c_tmo = int'(cfg_timeout);
    end
  endtask

  task automatic check_model();
    chk("match", match, m_match);
    chk("match_count", match_count, m_cnt);
    chk("done", done, m_done);
    chk("timed_out", timed_out, m_to);
    chk("busy", busy, m_st == 1);
    chk("state", state, m_st);
    chk("cfg_ready", cfg_ready, m_st != 1);
  endtask

  // Called just after a rising edge; drives inputs, steps one cycle, checks.
  task automatic cyc(input bit s, input bit a, input bit iv, input bit b);
    start = s; abort = a; in_valid = iv; in = b;
    @(posedge clk);
    m_step();
    #1;
    check_model();
  endtask

  task automatic do_cfg(input int pat, input int len, input bit ov, input int tgt, input int tmo);
    cfg_valid = 1; cfg_pattern = PAT_W'(pat); cfg_len = 4'(len); cfg_overlap = ov;
    cfg_target = CNT_W'(tgt); cfg_timeout = TO_W'(tmo);
    cyc(0, 0, 0, 0);
    cfg_valid = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cfg_ready"}, cfg_ready, 1);
    chk({tag, "_match"}, match, 0);
    chk({tag, "_match_count"}, match_count, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_timed_out"}, timed_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_state"}, state, 0);
  endtask

  typedef struct {
    bit cv; int pat; int len; bit ov; int tgt; int tmo;
    bit s; bit a; bit iv; bit b;
    bit em; int ec; int est; bit ed; bit eto;
  } vec_t;

  function automatic vec_t mk(bit cv, int pat, int len, bit ov, int tgt, int tmo,
                              bit s, bit a, bit iv, bit b,
                              bit em, int ec, int est, bit ed, bit eto);
    vec_t v;
    v.cv = cv; v.pat = pat; v.len = len; v.ov = ov; v.tgt = tgt; v.tmo = tmo;
    v.s = s; v.a = a; v.iv = iv; v.b = b;
    v.em = em; v.ec = ec; v.est = est; v.ed = ed; v.eto = eto;
    return v;
  endfunction

  initial begin
    vec_t tv[$];
    int nb;

    // Defaults (0010, len 4, overlap), stream 0,0,1,0,0,1,0, then abort.
    tv.push_back(mk(0,0,0,0,0,0, 1,0,0,0, 0,0,1,0,0));
    tv.push_back(mk(0,0,0,0,0,0, 0,0,1,0, 0,0,1,0,0));
    tv.push_back(mk(0,0,0,0,0,0, 0,0,1,0, 0,0,1,0,0));
    tv.push_back(mk(0,0,0,0,0,0, 0,0,1,1, 0,0,1,0,0));
    tv.push_back(mk(0,0,0,0,0,0, 0,0,1,0, 1,1,1,0,0));
    tv.push_back(mk(0,0,0,0,0,0, 0,0,1,0, 0,1,1,0,0));
    tv.push_back(mk(0,0,0,0,0,0, 0,0,1,1, 0,1,1,0,0));
    tv.push_back(mk(0,0,0,0,0,0, 0,0,1,0, 1,2,1,0,0));
    tv.push_back(mk(0,0,0,0,0,0, 0,0,0,0, 0,2,1,0,0));
    tv.push_back(mk(0,0,0,0,0,0, 0,1,0,0, 0,2,0,0,0));
    // 101, len 3, no overlap, target 2: stream 1,0,1,0,1,1,0,1.
    tv.push_back(mk(1,5,3,0,2,0, 0,0,0,0, 0,2,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0, 1,0,0,0, 0,0,1,0,0));
    tv.push_back(mk(0,0,0,0,0,0, 0,0,1,1, 0,0,1,0,0));
    tv.push_back(mk(0,0,0,0,0,0, 0,0,1,0, 0,0,1,0,0));
    tv.push_back(mk(0,0,0,0,0,0, 0,0,1,1, 1,1,1,0,0));
    tv.push_back(mk(0,0,0,0,0,0, 0,0,1,0, 0,1,1,0,0));
    tv.push_back(mk(0,0,0,0,0,0, 0,0,1,1, 0,1,1,0,0));
    tv.push_back(mk(0,0,0,0,0,0, 0,0,1,1, 0,1,1,0,0));
    tv.push_back(mk(0,0,0,0,0,0, 0,0,1,0, 0,1,1,0,0));
    tv.push_back(mk(0,0,0,0,0,0, 0,0,1,1, 1,2,2,1,0));
    tv.push_back(mk(0,0,0,0,0,0, 0,0,0,0, 0,2,2,1,0));

    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset = 0;

    foreach (tv[i]) begin
      cfg_valid = tv[i].cv; cfg_pattern = PAT_W'(tv[i].pat); cfg_len = 4'(tv[i].len);
      cfg_overlap = tv[i].ov; cfg_target = CNT_W'(tv[i].tgt); cfg_timeout = TO_W'(tv[i].tmo);
      cyc(tv[i].s, tv[i].a, tv[i].iv, tv[i].b);
      chk($sformatf("tv%0d_match", i), match, tv[i].em);
      chk($sformatf("tv%0d_count", i), match_count, tv[i].ec);
      chk($sformatf("tv%0d_state", i), state, tv[i].est);
      chk($sformatf("tv%0d_done", i), done, tv[i].ed);
      chk($sformatf("tv%0d_timed_out", i), timed_out, tv[i].eto);
    end
    cfg_valid = 0;

    // Timeout 10 with no matches: busy for exactly 10 cycles.
    do_cfg(5, 3, 1, 5, 10);
    cyc(1, 0, 0, 0);
    nb = 0;
    for (int i = 0; i < 30 && busy; i++) begin
      nb++;
      cyc(0, 0, 1, 1);
    end
    chk("to_busy_cycles", nb, 10);
    chk("to_done", done, 1);
    chk("to_timed_out", timed_out, 1);
    chk("to_count", match_count, 0);

    // Target match and timeout coincide: target wins.
    do_cfg(5, 3, 1, 1, 3);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 1);
    chk("tie_match", match, 1);
    chk("tie_done", done, 1);
    chk("tie_timed_out", timed_out, 0);
    chk("tie_count", match_count, 1);
    chk("tie_state", state, 2);

    // Abort on the completing bit drops the match; start+abort in RUN -> IDLE.
    do_cfg(5, 3, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 1);
    chk("abort_match", match, 0);
    chk("abort_state", state, 0);
    chk("abort_done", done, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    chk("start_abort_state", state, 0);

    // Reset mid-run with three matches counted.
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 1); cyc(0, 0, 1, 0); cyc(0, 0, 1, 1); cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 1); cyc(0, 0, 1, 0); cyc(0, 0, 1, 1);
    chk("pre_reset_count", match_count, 3);
    start = 0; in_valid = 0; reset = 1;
    #2;
    chk_reset_vals("midrun_reset");
    @(posedge clk);
    #1;
    reset = 0;
    m_reset();

    // Defaults back in force; a cfg write during RUN is refused.
    cyc(1, 0, 0, 0);
    chk("run_cfg_ready", cfg_ready, 0);
    cfg_valid = 1; cfg_pattern = PAT_W'(5); cfg_len = 4'd3; cfg_overlap = 0;
    cyc(0, 0, 1, 0);
    cfg_valid = 0;
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 1); cyc(0, 0, 1, 0);
    chk("default_pat_match", match, 1);
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0); cyc(0, 0, 1, 1); cyc(0, 0, 1, 0);
    chk("cfg_refused_match", match, 1);
    chk("cfg_refused_count", match_count, 1);
    cyc(0, 1, 0, 0);

    // Counter saturation with a single-bit pattern.
    do_cfg(1, 1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 300; i++) cyc(0, 0, 1, 1);
    chk("sat_count", match_count, CMAX);
    cyc(0, 1, 0, 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      cfg_valid   = ($urandom_range(0, 9) == 0);
      cfg_pattern = PAT_W'($urandom);
      cfg_len     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 3));
      cfg_overlap = 1'($urandom);
      cfg_target  = CNT_W'($urandom_range(0, 4));
      cfg_timeout = ($urandom_range(0, 2) == 0) ? TO_W'(0) : TO_W'($urandom_range(1, 25));
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
          $urandom_range(0, 3) != 0, 1'($urandom));
    end
    cfg_valid = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
